// File: rtl/crypt_pkg.sv
// Shared types and constants for the stream encryptor and its matching decryptor.
package crypt_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [1:0] {
      NOKEY  = 2'd0,
      IDLE   = 2'd1,
      STREAM = 2'd2
   } crypt_state_e;

   localparam byte_t DEFAULT_KEY_BYTE = 8'h00;

   // Modular byte add and its inverse; the decryptor relies on dec_byte.
   function automatic byte_t enc_byte(input byte_t plain, input byte_t key);
      return BYTE_W'(plain + key);
   endfunction

   function automatic byte_t dec_byte(input byte_t cipher, input byte_t key);
      return BYTE_W'(cipher - key);
   endfunction

endpackage

// File: rtl/enc_key_store.sv
// Key register file: SEC_LEN byte registers, one write port, combinational read by index.
module enc_key_store
   import crypt_pkg::*;
#(
   parameter  int unsigned SEC_LEN = 3,
   localparam int unsigned AW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  byte_t         wr_data,
   input  logic [AW-1:0] rd_idx,
   output byte_t         rd_data
);

   byte_t regs [SEC_LEN];

   // Out-of-range addresses (non power-of-two SEC_LEN) are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SEC_LEN); i++) begin
            regs[i] <= DEFAULT_KEY_BYTE;
         end
      end else if (wr_en && (32'(wr_addr) < SEC_LEN)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data = regs[rd_idx];

endmodule

// File: rtl/stream_encryptor.sv
// Byte-stream encryptor: out = in + key[idx] mod 256, one-deep registered output stage.
// Optional ENC_MSG_COUNT_EN adds a 16-bit completed-message counter output.
module stream_encryptor
   import crypt_pkg::*;
#(
   parameter  int unsigned MSG_LEN = 16,
   parameter  int unsigned SEC_LEN = 3,
   localparam int unsigned KW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_wr_en,
   input  logic [KW-1:0] key_wr_addr,
   input  logic [7:0]    key_wr_data,
   input  logic          key_commit,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_last,
   output logic          key_err
`ifdef ENC_MSG_COUNT_EN
   ,
   output logic [15:0]   msg_count
`endif
);

   localparam int unsigned CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   crypt_state_e  state;
   crypt_state_e  state_nxt;
   logic [KW-1:0] idx;
   logic [CW-1:0] cnt;
   byte_t         key_byte;
   logic          accept;
   logic          msg_end;
   logic          key_wr_ok;

   assign accept    = in_valid && in_ready;
   assign msg_end   = in_last || (32'(cnt) == MSG_LEN - 1);
   assign key_wr_ok = key_wr_en && (state != STREAM);

   enc_key_store #(
      .SEC_LEN (SEC_LEN)
   ) u_key_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (key_wr_ok),
      .wr_addr (key_wr_addr),
      .wr_data (key_wr_data),
      .rd_idx  (idx),
      .rd_data (key_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= NOKEY;
      end else begin
         state <= state_nxt;
      end
   end

   // in_ready follows out_ready combinationally so the output stage never bubbles.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         NOKEY: begin
            if (key_commit) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            in_ready = !out_valid || out_ready;
            if (accept && !msg_end) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            in_ready = !out_valid || out_ready;
            if (accept && msg_end) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = NOKEY;
         end
      endcase
   end

   // Key index and in-message byte position; both restart at a message boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (msg_end) begin
            idx <= '0;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
            idx <= (32'(idx) == SEC_LEN - 1) ? '0 : idx + KW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= enc_byte(in_data, key_byte);
         out_last  <= msg_end;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_err <= 1'b0;
      end else if (key_wr_en && (state == STREAM)) begin
         key_err <= 1'b1;
      end
   end

`ifdef ENC_MSG_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_count <= 16'h0000;
      end else if (out_valid && out_ready && out_last) begin
         msg_count <= msg_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_encryptor.sv
// Self-checking bench for stream_encryptor against a message-level byte-add model.
module tb_stream_encryptor;
   import crypt_pkg::*;

   localparam int MSG_LEN = 16;
   localparam int SEC_LEN = 3;
   localparam int KW      = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_wr_en;
   logic [KW-1:0] key_wr_addr;
   logic [7:0]    key_wr_data;
   logic          key_commit;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic          out_last;
   logic          key_err;
`ifdef ENC_MSG_COUNT_EN
   logic [15:0]   msg_count;
`endif

   int          errors = 0;
   int          checks = 0;
   int          msgs_done = 0;
   byte_t       kmod [SEC_LEN];
   logic [8:0]  got [$];
   logic [8:0]  exp [$];

   always #5 clk = ~clk;

   stream_encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_wr_en   (key_wr_en),
      .key_wr_addr (key_wr_addr),
      .key_wr_data (key_wr_data),
      .key_commit  (key_commit),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .key_err     (key_err)
`ifdef ENC_MSG_COUNT_EN
      ,
      .msg_count   (msg_count)
`endif
   );

   // Capture every output handshake; it completes at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got.push_back({out_last, out_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte i of a stream uses key[(i mod MSG_LEN) mod SEC_LEN].
   function automatic void build_exp(input byte_t d[$], input bit has_last);
      exp.delete();
      for (int i = 0; i < d.size(); i++) begin
         int    pos = i % MSG_LEN;
         logic  lst = (has_last && (i == d.size() - 1)) || (pos == MSG_LEN - 1);
         byte_t c   = 8'(d[i] + kmod[pos % SEC_LEN]);
         exp.push_back({lst, c});
         if (lst) msgs_done++;
      end
   endfunction

   task automatic fill(output byte_t q[$], input int n);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
   endtask

   task automatic key_write(input int a, input byte_t d, input bit applies);
      key_wr_en   = 1'b1;
      key_wr_addr = KW'(a);
      key_wr_data = d;
      tick();
      key_wr_en = 1'b0;
      if (applies) kmod[a] = d;
   endtask

   task automatic send(input byte_t d[$], input bit has_last, input bit rnd);
      for (int i = 0; i < d.size(); i++) begin
         bit acc;
         int cyc;
         acc      = 1'b0;
         cyc      = 0;
         in_valid = 1'b1;
         in_data  = d[i];
         in_last  = has_last && (i == d.size() - 1);
         while (!acc && cyc < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            tick();
            cyc++;
         end
         checks++;
         if (!acc) begin
            errors++;
            $display("FAIL send_accept byte %0d: in_ready never seen, required 1", i);
         end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic drain(input int n);
      int cyc = 0;
      out_ready = 1'b1;
      while (got.size() < n && cyc < 300) begin
         tick();
         cyc++;
      end
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      got.delete();
      msgs_done = 0;
      for (int i = 0; i < SEC_LEN; i++) kmod[i] = DEFAULT_KEY_BYTE;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      if (key_err !== 1'b0) begin errors++; $display("FAIL rst_key_err got=%b exp=0", key_err); end
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL nokey_in_ready cyc%0d got=%b exp=0", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      logic [8:0] lit [3] = '{9'h093, 9'h08E, 9'h17A};
      byte_t      d [$] = '{8'h48, 8'h49, 8'h21};
      key_write(0, 8'h4B, 1'b1);
      key_write(1, 8'h45, 1'b1);
      // Last key byte lands together with commit; a byte offered that cycle must wait.
      key_wr_en   = 1'b1;
      key_wr_addr = KW'(2);
      key_wr_data = 8'h59;
      key_commit  = 1'b1;
      in_valid    = 1'b1;
      in_data     = 8'h48;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL commit_cycle_in_ready got=%b exp=0", in_ready); end
      tick();
      key_wr_en  = 1'b0;
      key_commit = 1'b0;
      in_valid   = 1'b0;
      kmod[2]    = 8'h59;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_commit_in_ready got=%b exp=1", in_ready); end
      tick();
      send(d, 1'b1, 1'b0);
      drain(3);
      build_exp(d, 1'b1);
      checks++;
      if (got.size() != 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== lit[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], lit[i]); end
      end
      got.delete();
   endtask

   task automatic test_wrap();
      byte_t d [$];
      d = '{8'hC8, 8'($urandom), 8'($urandom), 8'hC8};
      send(d, 1'b1, 1'b0);
      drain(4);
      build_exp(d, 1'b1);
      checks += 3;
      if (got.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", got.size()); end
      if (got.size() == 4 && got[0] !== 9'h013) begin errors++; $display("FAIL wrap_first got=%h exp=013", got[0]); end
      if (got.size() == 4 && got[3] !== 9'h113) begin errors++; $display("FAIL wrap_fourth got=%h exp=113", got[3]); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
      end
      got.delete();
   endtask

   task automatic test_backpressure();
      byte_t d [$];
      byte_t held;
      fill(d, 8);
      build_exp(d, 1'b1);
      send(d[0:2], 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = d[3];
      held      = out_data;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks += 3;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
         if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", i, out_valid); end
         if (out_data !== exp[2][7:0]) begin errors++; $display("FAIL bp_out_data cyc%0d got=%h exp=%h", i, out_data, exp[2][7:0]); end
         tick();
      end
      checks++;
      if (out_data !== held) begin errors++; $display("FAIL bp_stable got=%h exp=%h", out_data, held); end
      out_ready = 1'b1;
      send(d[3:$], 1'b1, 1'b0);
      drain(8);
      checks++;
      if (got.size() != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
      end
      got.delete();
   endtask

   task automatic test_key_err();
      byte_t d [$];
      fill(d, 10);
      checks++;
      if (key_err !== 1'b0) begin errors++; $display("FAIL key_err_pre got=%b exp=0", key_err); end
      build_exp(d, 1'b1);
      send(d[0:3], 1'b0, 1'b1);
      key_write(0, 8'h00, 1'b0);
      @(negedge clk);
      checks++;
      if (key_err !== 1'b1) begin errors++; $display("FAIL key_err_set got=%b exp=1", key_err); end
      tick();
      send(d[4:$], 1'b1, 1'b1);
      drain(10);
      checks++;
      if (got.size() != 10) begin errors++; $display("FAIL kerr_count got=%0d exp=10", got.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL kerr_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
      end
      got.delete();
   endtask

   task automatic test_cutoff();
      byte_t d [$];
      fill(d, 18);
      build_exp(d, 1'b1);
      send(d, 1'b1, 1'b1);
      drain(18);
      checks += 3;
      if (got.size() != 18) begin errors++; $display("FAIL cut_count got=%0d exp=18", got.size()); end
      if (got.size() == 18 && got[15][8] !== 1'b1) begin errors++; $display("FAIL cut_last16 got=%b exp=1", got[15][8]); end
      if (got.size() == 18 && got[16] !== {1'b0, 8'(d[16] + kmod[0])}) begin
         errors++; $display("FAIL cut_byte17 got=%h exp=%h", got[16], {1'b0, 8'(d[16] + kmod[0])});
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL cut_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
      end
      got.delete();
   endtask

   task automatic test_random();
      for (int m = 0; m < 5; m++) begin
         byte_t d [$];
         int    n = $urandom_range(1, 20);
         fill(d, n);
         build_exp(d, 1'b1);
         send(d, 1'b1, 1'b1);
         drain(n);
         checks++;
         if (got.size() != n) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", m, got.size(), n); end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", m, i, got[i], exp[i]); end
         end
         got.delete();
      end
   endtask

   task automatic test_reset_mid();
      byte_t d [$];
      byte_t z [$];
      fill(d, 6);
      send(d[0:1], 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
      if (key_err !== 1'b0) begin errors++; $display("FAIL mid_rst_key_err got=%b exp=0", key_err); end
      do_reset();
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = d[2];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_nokey cyc%0d in_ready=%b out_valid=%b exp=0/0", i, in_ready, out_valid);
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (got.size() != 0) begin errors++; $display("FAIL mid_rst_leak got=%0d exp=0", got.size()); end
      // Commit with no writes: reset key is all zero, so ciphertext equals plaintext.
      key_commit = 1'b1;
      tick();
      key_commit = 1'b0;
      z = '{8'h5C};
      send(z, 1'b1, 1'b0);
      drain(1);
      msgs_done++;
      checks++;
      if (got.size() != 1 || got[0] !== 9'h15C) begin errors++; $display("FAIL zero_key got=%h exp=15c", got.size() ? got[0] : 9'h0); end
      got.delete();
      for (int i = 0; i < SEC_LEN; i++) key_write(i, 8'($urandom), 1'b1);
      send(d, 1'b1, 1'b1);
      drain(6);
      msgs_done++;
      checks++;
      if (got.size() != 6) begin errors++; $display("FAIL rt_count got=%0d exp=6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         byte_t p = dec_byte(got[i][7:0], kmod[(i % MSG_LEN) % SEC_LEN]);
         checks++;
         if (p !== d[i]) begin errors++; $display("FAIL roundtrip_byte%0d got=%h exp=%h", i, p, d[i]); end
      end
      got.delete();
`ifdef ENC_MSG_COUNT_EN
      checks++;
      if (msg_count !== 16'(msgs_done)) begin errors++; $display("FAIL msg_count got=%0d exp=%0d", msg_count, msgs_done); end
`endif
   endtask

   initial begin
      rst_n       = 1'b0;
      key_wr_en   = 1'b0;
      key_wr_addr = '0;
      key_wr_data = 8'h00;
      key_commit  = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      in_last     = 1'b0;
      out_ready   = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_key_err();
      test_cutoff();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_encryptor.md
STREAM_ENCRYPTOR -- requirements
Module: stream_encryptor

Interface
REQ-001 SHALL have parameter MSG_LEN, default 16: maximum bytes per message; a longer message is cut off by a forced out_last.
REQ-002 SHALL have parameter SEC_LEN, default 3: key length in bytes, legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_wr_en, input, 1 bit: key byte write strobe.
REQ-006 SHALL have port key_wr_addr, input, $clog2(SEC_LEN) bits (minimum 1): key byte index.
REQ-007 SHALL have port key_wr_data, input, 8 bits: key byte value.
REQ-008 SHALL have port key_commit, input, 1 bit: marks the key valid.
REQ-009 SHALL have ports in_valid, in_ready, in_data[7:0] and in_last: plaintext stream (in, out, in, in).
REQ-010 SHALL have ports out_valid, out_ready, out_data[7:0] and out_last: ciphertext stream (out, in, out, out).
REQ-011 SHALL have port key_err, output, 1 bit: sticky flag for an illegal key write.

Function
REQ-012 SHALL compute out_data = (in_data + key[idx]) mod 256, with an 8-bit wrap and no carry out; this is the exact inverse of the team decryptor.
REQ-013 SHALL use key index idx, which starts at 0 and advances on each accepted byte (in_valid && in_ready).
REQ-014 SHALL wrap idx from SEC_LEN-1 back to 0.
REQ-015 SHALL return idx to 0 after accepting a byte with in_last=1, or after accepting the MSG_LEN-th byte.
REQ-016 SHALL have FSM states NOKEY, IDLE and STREAM, with these transitions:
- NOKEY to IDLE on key_commit.
- IDLE to STREAM on the first accepted byte when that byte is not also the last.
- STREAM to IDLE on acceptance of the last byte.
REQ-017 SHALL hold in_ready=0 in NOKEY.
REQ-018 SHALL otherwise drive in_ready = !out_valid || out_ready, a one-deep output register with no bubbles.
REQ-019 SHALL have a latency of 1 cycle: a byte accepted at edge N appears on out_data at edge N+1.
REQ-020 SHALL keep out_data and out_last stable while out_valid && !out_ready.
REQ-021 SHALL set out_last = in_last OR (byte count == MSG_LEN).
REQ-022 SHALL apply key writes only in NOKEY and IDLE.
REQ-023 SHALL ignore a key write during STREAM, leave the key unchanged and set key_err.
REQ-024 SHALL ignore key_commit outside NOKEY.
REQ-025 SHALL apply a key write that coincides with key_commit before the commit takes effect.
REQ-026 SHALL accept a byte in the same cycle as the NOKEY to IDLE commit only from the following cycle onward.

Reset
REQ-027 SHALL, while rst_n=0, immediately force the FSM to NOKEY, idx to 0 and all key bytes to 0x00.
REQ-028 SHALL, while rst_n=0, immediately force out_valid=0, out_data=0x00, out_last=0, in_ready=0 and key_err=0.
REQ-029 SHALL drop any byte in flight when reset asserts mid-message; no partial output survives.

Configuration
REQ-030 SHALL, when ENC_MSG_COUNT_EN is defined, add output msg_count[15:0], which:
- resets to 0;
- increments by 1 on each accepted out_last byte;
- wraps from 0xFFFF to 0.
REQ-031 SHALL, when ENC_MSG_COUNT_EN is undefined, have no msg_count port and no counter logic, with all other behaviour unchanged.

Structure
REQ-032 SHALL take the byte_t typedef, the FSM state enum and the default key constant from shared package crypt_pkg, which the decryptor also uses.
REQ-033 SHALL place the key register file in sub-module enc_key_store, which has:
- SEC_LEN registers;
- a write port;
- a combinational read by idx.

Verification
REQ-034 SHALL cover basic encryption: key "KEY" (0x4B 0x45 0x59), commit, then stream "HI!" (0x48 0x49 0x21, last on the third byte) -> out 0x93 0x8E 0x7A, out_last on the third byte.
REQ-035 SHALL cover wrap-around: key byte 0 = 0x4B, in 0xC8 -> out 0x13, with idx cycling 0,1,2,0 over a 4-byte message.
REQ-036 SHALL cover backpressure: hold out_ready=0 for 3 cycles mid-message -> in_ready=0, out_data stable, no byte lost or duplicated.
REQ-037 SHALL cover a key write in STREAM: write 0x00 to key[0] mid-message -> key_err=1, ciphertext unchanged versus the reference model.
REQ-038 SHALL cover the MSG_LEN cutoff: 17 bytes with no in_last and MSG_LEN=16 -> out_last on byte 16, byte 17 encrypted with key[0].
REQ-039 SHALL cover reset mid-message plus round-trip: assert rst_n=0 after 2 bytes -> out_valid=0 and NOKEY; re-load the key, encrypt, feed the result to the decryptor -> original plaintext.
